// File: rtl/cacheline_adapter.sv
// Cache-line to memory-burst adapter: turns one 256-bit line request into a
// 4-beat x 64-bit burst on the memory side and returns a one-cycle line response.
module cacheline_adapter #(
    parameter int unsigned BEATS  = 4,
    parameter int unsigned BEAT_W = 64,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BEATS*BEAT_W-1:0]   line_i,
    output logic [BEATS*BEAT_W-1:0]   line_o,
    input  logic [ADDR_W-1:0]         address_i,
    input  logic                      read_i,
    input  logic                      write_i,
    output logic                      resp_o,
    input  logic [BEAT_W-1:0]         burst_i,
    output logic [BEAT_W-1:0]         burst_o,
    output logic [ADDR_W-1:0]         address_o,
    output logic                      read_o,
    output logic                      write_o,
    input  logic                      resp_i
);

    localparam int unsigned LINE_W = BEATS * BEAT_W;
    localparam int unsigned OFFS   = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [LINE_W-1:0]   line_q;
    logic                unused_offs;

    // Line offset bits are dropped; the burst address is always line aligned.
    assign unused_offs = ^address_i[OFFS-1:0];

    // line_q shifts down one beat per acknowledge, so the current write beat
    // always sits in the low slot (same order as indexing by cnt).
    assign burst_o = line_q[BEAT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            line_q    <= '0;
            line_o    <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read_i) begin
                        address_o <= {address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
                        cnt       <= '0;
                        read_o    <= 1'b1;
                        state     <= READ;
                    end else if (write_i) begin
                        address_o <= {address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
                        line_q    <= line_i;
                        cnt       <= '0;
                        write_o   <= 1'b1;
                        state     <= WRITE;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        for (int unsigned b = 0; b < BEATS; b++) begin
                            if (cnt == CNT_W'(b)) begin
                                line_o[b*BEAT_W +: BEAT_W] <= burst_i;
                            end
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        line_q <= line_q >> BEAT_W;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    read_o  <= 1'b0;
                    write_o <= 1'b0;
                    resp_o  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cacheline_adapter.md
# cacheline_adapter

Bridges the L2/cache-side 256-bit line interface to the 64-bit burst interface of the physical memory model (ParamMemory, 4 beats × 64 bits). It is the initiator end of the burst protocol: it drives address and read/write strobes, collects or supplies one beat per memory response, and returns a single-cycle line response upstream. It sits between the last-level cache/arbiter and `mem_itf` in the top level.

## Interface

**Parameters**
- `BEATS`, 4: beats per line burst.
- `BEAT_W`, 64: bits per beat.
- `ADDR_W`, 32: address width.
- Derived: `LINE_W = BEATS*BEAT_W` (256); `OFFS = log2(LINE_W/8)` (5).

**Ports**
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `line_i`  in  LINE_W  write line from cache.
- `line_o`  out  LINE_W  read line to cache.
- `address_i`  in  ADDR_W  line address from cache.
- `read_i`  in  1  cache line read request, level, held until `resp_o`.
- `write_i`  in  1  cache line write request, level, held until `resp_o`.
- `resp_o`  out  1  line transaction complete, one-cycle pulse.
- `burst_i`  in  BEAT_W  read beat from memory.
- `burst_o`  out  BEAT_W  write beat to memory.
- `address_o`  out  ADDR_W  line-aligned burst address.
- `read_o`  out  1  memory read strobe.
- `write_o`  out  1  memory write strobe.
- `resp_i`  in  1  memory beat acknowledge, one per beat.

## Operation

- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `read_i`: latch `address_i`, go to READ.
  - Otherwise `write_i`: latch `address_i` and `line_i`, go to WRITE.
  - Read has priority when both are high. The beat counter is cleared on entry to either state.
- **READ**
  - `read_o = 1`.
  - On each `resp_i`, store `burst_i` into `line_o[cnt*BEAT_W +: BEAT_W]` and increment `cnt`.
  - On `resp_i` with `cnt == BEATS-1`, go to DONE.
- **WRITE**
  - `write_o = 1`.
  - `burst_o = line_q[cnt*BEAT_W +: BEAT_W]`; beat 0 is bits 63:0.
  - On `resp_i`, advance `cnt`.
  - On `resp_i` with `cnt == BEATS-1`, go to DONE.
- **DONE**
  - `resp_o = 1` for exactly one cycle, then unconditionally return to IDLE.
  - `line_o` is valid in DONE and holds until the next read's first beat.
- Outputs are Moore-decoded from state:
  - `read_o` is high only in READ.
  - `write_o` is high only in WRITE.
  - `resp_o` is high only in DONE.
- `address_o = {addr_q[ADDR_W-1:OFFS], OFFS'b0}`. It is held constant for the whole burst; the low offset bits of `address_i` are discarded.
- `resp_i` in IDLE or DONE is ignored. The counter does not move.
- `read_i`/`write_i` changes during a burst are ignored; the latched request completes.
- The counter is `log2(BEATS)` bits. Wrap after the last beat is irrelevant because the state leaves READ/WRITE.

## Timing

- Reset, asynchronous on `rst_n` low:
  - State = IDLE, `cnt` = 0.
  - `read_o`, `write_o`, `resp_o` = 0.
  - `line_o`, `burst_o`, `address_o` = 0.
- Reset mid-burst aborts immediately. Strobes drop asynchronously and no `resp_o` is produced.
- Request sampled at edge E0: the strobe is high from E0 onward.
- Last `resp_i` sampled at edge En: `resp_o` is high in the cycle after En, and the strobe is low in that same cycle.
- Back-to-back bursts are permitted with no extra gap beyond the DONE cycle. The upstream requester must drop its request in the cycle following `resp_o`.
- Minimum transaction: 1 (strobe) + BEATS (zero-wait beats) + 1 (DONE) cycles = 6 cycles for BEATS=4.
- Beats may be separated by any number of cycles with `resp_i` low. The strobe and address stay stable throughout.

## Test plan

- **Read, zero-wait.** `read_i`, `address_i = 0x0000_1234`, four consecutive `resp_i` with beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44`.
  - Expect `address_o = 0x0000_1220`.
  - Expect `line_o = {44..44, 33..33, 22..22, 11..11}`.
  - Expect `resp_o` high for one cycle; `read_o` high for 4 cycles.
- **Write with waits.** `write_i`, `line_i = {D3,D2,D1,D0}`, `resp_i` gaps of 0, 3, 7, 1 cycles.
  - Expect `burst_o` = D0, D1, D2, D3 in order, each held until its `resp_i`.
  - Expect `write_o` held continuously; single `resp_o` pulse.
- **Simultaneous requests.** `read_i` and `write_i` both high in IDLE.
  - Expect a read burst, `write_o = 0` throughout.
- **Stray response.** `resp_i` pulsed in IDLE.
  - Expect no state change. A following read still captures 4 beats starting at beat 0.
- **Reset mid-read.** `rst_n` low after beat 2.
  - Expect all outputs 0 immediately and no `resp_o`. A new read completes normally with correct beat order.
- **Back-to-back.** Read then write with requests re-asserted the cycle after `resp_o`.
  - Expect exactly one DONE cycle between bursts and correct data on both.
